alu_req_arbiter: RTL and testbench

//  Shares one ALU (add/sub/mul/div, variable latency) between NUM_REQ requesters.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 33 +++
 rtl/alu_req_arbiter.sv | 172 +++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request arbiter: op codes, the command
// layout carried on each requester slot, and result constants.
package alu_pkg;

   // ALU operation codes as carried in cmd[9:8].
   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_MUL = 2'd2,
      ALU_DIV = 2'd3
   } alu_op_e;

   // One requester command: {op[9:8], b[7:4], a[3:0]}.
   typedef struct packed {
      alu_op_e    op;
      logic [3:0] b;
      logic [3:0] a;
   } alu_cmd_t;

   localparam int                CMD_W      = 10;
   localparam int                RES_W      = 9;
   localparam int                WD_W       = 8;
   localparam logic [RES_W-1:0]  ERR_RESULT = 9'h1FF;

   // A divide by zero is answered locally and never reaches the ALU.
   function automatic logic is_div_zero(input alu_cmd_t cmd);
      return (cmd.op == ALU_DIV) && (cmd.b == 4'd0);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches req starting just after ptr,
// wrapping, and returns the first hit as a one-hot grant plus its index.
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               found
);

   logic [ID_W-1:0] cand;

   // Scan ptr+1, ptr+2, ... ptr (wrapping); the first asserted request wins.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = ID_W'((int'(ptr) + k) % NUM_REQ);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant_idx   = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one variable-latency ALU between NUM_REQ requesters. Round-robin
// grant, one operation in flight, results returned tagged with the owner's
// id. Divide-by-zero is answered locally; a watchdog aborts lost responses.
module alu_req_arbiter
   import alu_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int TIMEOUT = 15,
   parameter  int CNT_W   = 16,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*CMD_W-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     alu_cmd_valid,
   input  logic                     alu_cmd_ready,
   output logic [1:0]               alu_op,
   output logic [3:0]               alu_a,
   output logic [3:0]               alu_b,
   input  logic                     alu_rsp_valid,
   input  logic [RES_W-1:0]         alu_rsp_data,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [RES_W-1:0]         rsp_data,
   output logic                     rsp_err,
   output logic [CNT_W-1:0]         ops_done
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ISSUE    = 2'd1,
      S_WAIT_RSP = 2'd2,
      S_DELIVER  = 2'd3
   } state_e;

   localparam logic [ID_W-1:0] PTR_INIT = ID_W'(NUM_REQ - 1);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

   state_e             state_q, state_d;
   logic [ID_W-1:0]    ptr_q;
   logic [ID_W-1:0]    id_q;
   alu_cmd_t           cmd_q;
   alu_cmd_t           sel_cmd;
   logic [WD_W-1:0]    wd_q;
   logic               cmd_valid_q;
   logic               rsp_valid_q;
   logic [RES_W-1:0]   rsp_data_q;
   logic               rsp_err_q;
   logic [CNT_W-1:0]   ops_done_q;

   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_idx;
   logic               grant_found;
   logic               take;
   logic               capture;
   logic               abort;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .req       (req_valid),
      .ptr       (ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .found     (grant_found)
   );

   // Pick out the granted requester's command slot.
   always_comb begin
      sel_cmd = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) sel_cmd = alu_cmd_t'(req_data[CMD_W*i +: CMD_W]);
      end
   end

   // Accept strobe is combinational and only offered while idle and out of reset.
   always_comb begin
      req_ready = '0;
      if (state_q == S_IDLE && !reset) req_ready = grant;
   end

   // Next-state logic and the one-cycle event flags that steer the datapath.
   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      capture = 1'b0;
      abort   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (grant_found) begin
               take    = 1'b1;
               state_d = is_div_zero(sel_cmd) ? S_DELIVER : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (alu_cmd_ready) state_d = S_WAIT_RSP;
         end
         S_WAIT_RSP: begin
            // A response arriving on the watchdog's last cycle still wins.
            if (alu_rsp_valid) begin
               capture = 1'b1;
               state_d = S_DELIVER;
            end else if (wd_q == WD_LIMIT) begin
               abort   = 1'b1;
               state_d = S_DELIVER;
            end
         end
         S_DELIVER: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register, latched command, watchdog, response and counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         ptr_q       <= PTR_INIT;
         id_q        <= '0;
         cmd_q       <= '0;
         wd_q        <= '0;
         cmd_valid_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         ops_done_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples pre-edge values, whatever the statement order.
         state_q     <= state_d;
         cmd_valid_q <= (state_d == S_ISSUE);
         rsp_valid_q <= (state_d == S_DELIVER);

         if (take) begin
            cmd_q <= sel_cmd;
            id_q  <= grant_idx;
            ptr_q <= grant_idx;
            if (is_div_zero(sel_cmd)) begin
               rsp_data_q <= ERR_RESULT;
               rsp_err_q  <= 1'b1;
            end
         end

         if (state_q == S_WAIT_RSP) wd_q <= wd_q + WD_W'(1);
         else                       wd_q <= '0;

         if (capture) begin
            rsp_data_q <= alu_rsp_data;
            rsp_err_q  <= 1'b0;
         end else if (abort) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
         end

         if (state_q == S_DELIVER && rsp_ready) ops_done_q <= ops_done_q + CNT_W'(1);
      end
   end

   assign alu_cmd_valid = cmd_valid_q;
   assign alu_op        = cmd_q.op;
   assign alu_a         = cmd_q.a;
   assign alu_b         = cmd_q.b;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_id        = id_q;
   assign rsp_data      = rsp_data_q;
   assign rsp_err       = rsp_err_q;
   assign ops_done      = ops_done_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: transaction-level reference model
// compared every cycle, an ALU emulator with configurable latency, directed
// scenarios with literal expectations, then a randomized soak.
module tb_alu_req_arbiter;
   import alu_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int TIMEOUT = 15;
   localparam int CNT_W   = 16;
   localparam int ID_W    = 2;

   logic                     clk;
   logic                     reset;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*CMD_W-1:0] req_data;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     alu_cmd_valid;
   logic                     alu_cmd_ready;
   logic [1:0]               alu_op;
   logic [3:0]               alu_a;
   logic [3:0]               alu_b;
   logic                     alu_rsp_valid;
   logic [RES_W-1:0]         alu_rsp_data;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [ID_W-1:0]          rsp_id;
   logic [RES_W-1:0]         rsp_data;
   logic                     rsp_err;
   logic [CNT_W-1:0]         ops_done;

   alu_req_arbiter #(
      .NUM_REQ (NUM_REQ),
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .alu_cmd_valid (alu_cmd_valid),
      .alu_cmd_ready (alu_cmd_ready),
      .alu_op        (alu_op),
      .alu_a         (alu_a),
      .alu_b         (alu_b),
      .alu_rsp_valid (alu_rsp_valid),
      .alu_rsp_data  (alu_rsp_data),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_id        (rsp_id),
      .rsp_data      (rsp_data),
      .rsp_err       (rsp_err),
      .ops_done      (ops_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference arithmetic ----------------
   function automatic int rr_pick(input logic [NUM_REQ-1:0] req, input int last);
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (req[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
      end
      return -1;
   endfunction

   function automatic logic [RES_W-1:0] alu_fn(input alu_cmd_t c);
      int r;
      case (c.op)
         ALU_ADD: r = int'(c.a) + int'(c.b);
         ALU_SUB: r = int'(c.a) - int'(c.b);
         ALU_MUL: r = int'(c.a) * int'(c.b);
         default: r = (c.b == 4'd0) ? 511 : int'(c.a) / int'(c.b);
      endcase
      return RES_W'(r);
   endfunction

   function automatic alu_cmd_t mk(input alu_op_e op, input int a, input int b);
      alu_cmd_t c;
      c.op = op;
      c.a  = 4'(a);
      c.b  = 4'(b);
      return c;
   endfunction

   // ---------------- model state ----------------
   bit               m_busy, m_issue, m_wait, m_deliver;
   int               m_wait_cnt;
   int               m_last;
   int               m_id;
   alu_cmd_t         m_cmd;
   logic [RES_W-1:0] m_data;
   logic             m_err;
   logic [CNT_W-1:0] m_count;
   int               grant_log[$];
   int               cmd_cycles = 0;
   int               wait_start = 0;
   int               rise_cyc = 0;
   bit               prev_rsp_valid;
   int               got_id;
   logic [RES_W-1:0] got_data;
   logic             got_err;

   // Compare DUT outputs with the model each cycle, then apply the coming edge.
   initial begin
      int       exp_g;
      alu_cmd_t cur;
      m_busy = 0; m_issue = 0; m_wait = 0; m_deliver = 0;
      m_last = NUM_REQ - 1; m_count = '0; prev_rsp_valid = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            check("reset_req_ready", 32'(req_ready), 0);
            check("reset_alu_cmd_valid", 32'(alu_cmd_valid), 0);
            check("reset_alu_cmd", 32'({alu_op, alu_b, alu_a}), 0);
            check("reset_rsp_valid", 32'(rsp_valid), 0);
            check("reset_rsp_fields", 32'({rsp_id, rsp_err, rsp_data}), 0);
            check("reset_ops_done", 32'(ops_done), 0);
            m_busy = 0; m_issue = 0; m_wait = 0; m_deliver = 0;
            m_last = NUM_REQ - 1; m_count = '0; prev_rsp_valid = 0;
         end else begin
            exp_g = m_busy ? -1 : rr_pick(req_valid, m_last);
            check("req_ready", 32'(req_ready), (exp_g >= 0) ? (32'd1 << exp_g) : 32'd0);
            check("alu_cmd_valid", 32'(alu_cmd_valid), 32'(m_issue));
            if (m_issue) check("alu_cmd", 32'({alu_op, alu_b, alu_a}), 32'(m_cmd));
            check("rsp_valid", 32'(rsp_valid), 32'(m_deliver));
            if (m_deliver) begin
               check("rsp_id", 32'(rsp_id), 32'(m_id));
               check("rsp_data", 32'(rsp_data), 32'(m_data));
               check("rsp_err", 32'(rsp_err), 32'(m_err));
            end
            check("ops_done", 32'(ops_done), 32'(m_count));
            if (alu_cmd_valid) cmd_cycles++;
            if (rsp_valid && !prev_rsp_valid) rise_cyc = cyc;
            prev_rsp_valid = rsp_valid;

            if (exp_g >= 0) begin
               grant_log.push_back(exp_g);
               cur    = alu_cmd_t'(req_data[CMD_W*exp_g +: CMD_W]);
               m_busy = 1; m_last = exp_g; m_id = exp_g; m_cmd = cur;
               if (cur.op == ALU_DIV && cur.b == 4'd0) begin
                  m_deliver = 1; m_data = ERR_RESULT; m_err = 1;
               end else begin
                  m_issue = 1;
               end
            end else if (m_issue) begin
               if (alu_cmd_ready) begin
                  m_issue = 0; m_wait = 1; m_wait_cnt = 0; wait_start = cyc + 1;
               end
            end else if (m_wait) begin
               m_wait_cnt++;
               if (alu_rsp_valid) begin
                  m_wait = 0; m_deliver = 1; m_data = alu_fn(m_cmd); m_err = 0;
               end else if (m_wait_cnt == TIMEOUT + 1) begin
                  m_wait = 0; m_deliver = 1; m_data = '0; m_err = 1;
               end
            end else if (m_deliver && rsp_ready) begin
               got_id = int'(rsp_id); got_data = rsp_data; got_err = rsp_err;
               m_deliver = 0; m_busy = 0; m_count++;
            end
         end
      end
   end

   // ---------------- ALU emulator ----------------
   int cfg_lat = 0;      // <0 random, >TIMEOUT never answers
   int cfg_rdy_max = 0;
   int pulse_req = 0;
   int pulse_done = 0;

   initial begin
      bit       in_flight;
      int       rdy_wait, rsp_wait, lat, r;
      alu_cmd_t cap;
      in_flight = 0; rdy_wait = 0; rsp_wait = 0;
      alu_cmd_ready = 1'b0; alu_rsp_valid = 1'b0; alu_rsp_data = '0;
      forever begin
         @(posedge clk);
         #1;
         alu_cmd_ready = 1'b0;
         alu_rsp_valid = 1'b0;
         if (reset) begin
            in_flight = 0; rdy_wait = 0;
         end else if (pulse_req != pulse_done) begin
            alu_rsp_valid = 1'b1; alu_rsp_data = 9'h0AA; pulse_done = pulse_req;
         end else if (in_flight) begin
            if (rsp_wait == 0) begin
               alu_rsp_valid = 1'b1; alu_rsp_data = alu_fn(cap); in_flight = 0;
               rdy_wait = (cfg_rdy_max > 0) ? int'($urandom_range(cfg_rdy_max, 0)) : 0;
            end else begin
               rsp_wait--;
            end
         end else if (alu_cmd_valid) begin
            if (rdy_wait > 0) begin
               rdy_wait--;
            end else begin
               alu_cmd_ready = 1'b1;
               cap = alu_cmd_t'({alu_op, alu_b, alu_a});
               if (cfg_lat >= 0) lat = cfg_lat;
               else begin
                  r = int'($urandom_range(19, 0));
                  lat = (r == 0) ? TIMEOUT + 5 : (r == 1) ? TIMEOUT : int'($urandom_range(4, 0));
               end
               if (lat <= TIMEOUT) begin
                  in_flight = 1; rsp_wait = lat;
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input int id, input alu_cmd_t cmd);
      int base, n;
      @(posedge clk);
      #1;
      req_data[CMD_W*id +: CMD_W] = cmd;
      req_valid[id] = 1'b1;
      base = grant_log.size();
      n = 0;
      while (grant_log.size() == base && n < 50) begin
         @(posedge clk);
         n++;
      end
      check("send_grant_bound", 32'(n < 50), 1);
      if (grant_log.size() > base) check("send_grant_id", 32'(grant_log[base]), 32'(id));
      #1;
      req_valid[id] = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int n;
      n = 0;
      while (m_busy && n < max) begin
         @(posedge clk);
         n++;
      end
      check("idle_bound", 32'(n < max), 1);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   // ---------------- test sequence ----------------
   initial begin
      int       base, n, exp1[5];
      alu_cmd_t c;
      exp1 = '{0, 1, 2, 3, 0};
      reset = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("post_reset_ops_done", 32'(ops_done), 0);
      check("post_reset_cmd_valid", 32'(alu_cmd_valid), 0);
      check("post_reset_rsp_valid", 32'(rsp_valid), 0);

      // 1: everyone requests ADD, ALU answers at once.
      cfg_lat = 0; cfg_rdy_max = 0;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) req_data[CMD_W*i +: CMD_W] = mk(ALU_ADD, i, 1);
      req_valid = '1;
      base = grant_log.size();
      n = 0;
      while (grant_log.size() < base + 5 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1 req_valid = '0;
      wait_idle(50);
      for (int k = 0; k < 5; k++) begin
         if (grant_log.size() > base + k) check("t1_grant_order", 32'(grant_log[base + k]), 32'(exp1[k]));
      end
      check("t1_ops_done", 32'(ops_done), 5);
      check("t1_last_id", 32'(got_id), 0);

      // 2: MUL 7*9 from requester 1, ALU answers after 3 cycles.
      cfg_lat = 2;
      send(1, mk(ALU_MUL, 7, 9));
      wait_idle(50);
      check("t2_data", 32'(got_data), 63);
      check("t2_err", 32'(got_err), 0);
      check("t2_id", 32'(got_id), 1);

      // 3: divide by zero never reaches the ALU.
      n = cmd_cycles;
      send(2, mk(ALU_DIV, 5, 0));
      wait_idle(50);
      check("t3_no_alu_cmd", 32'(cmd_cycles - n), 0);
      check("t3_data", 32'(got_data), 32'h1FF);
      check("t3_err", 32'(got_err), 1);
      check("t3_id", 32'(got_id), 2);

      // 4: ALU never answers -> watchdog abort.
      cfg_lat = 100;
      send(0, mk(ALU_ADD, 3, 4));
      wait_idle(100);
      check("t4_data", 32'(got_data), 0);
      check("t4_err", 32'(got_err), 1);
      check("t4_latency", 32'(rise_cyc - wait_start), TIMEOUT + 1);

      // 4b: answer on the watchdog's last cycle wins.
      cfg_lat = TIMEOUT;
      send(3, mk(ALU_MUL, 3, 5));
      wait_idle(100);
      check("t4b_data", 32'(got_data), 15);
      check("t4b_err", 32'(got_err), 0);

      // 5: consumer stalls 10 cycles while others request.
      cfg_lat = 1;
      rsp_ready = 1'b0;
      send(3, mk(ALU_SUB, 2, 5));
      n = 0;
      while (!m_deliver && n < 50) begin
         @(posedge clk);
         n++;
      end
      check("t5_deliver_bound", 32'(n < 50), 1);
      #1;
      req_data[CMD_W*0 +: CMD_W] = mk(ALU_ADD, 1, 1);
      req_data[CMD_W*1 +: CMD_W] = mk(ALU_ADD, 2, 2);
      req_valid[1:0] = 2'b11;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("t5_still_valid", 32'(rsp_valid), 1);
      check("t5_no_ready", 32'(req_ready), 0);
      @(posedge clk);
      #1;
      req_valid = '0;
      rsp_ready = 1'b1;
      wait_idle(50);
      check("t5_data", 32'(got_data), 32'h1FD);
      check("t5_id", 32'(got_id), 3);

      // 6: reset during WAIT_RSP, then a stray ALU pulse.
      cfg_lat = 100;
      send(2, mk(ALU_ADD, 1, 1));
      n = 0;
      while (!m_wait && n < 50) begin
         @(posedge clk);
         n++;
      end
      check("t6_wait_bound", 32'(n < 50), 1);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      pulse_req++;
      repeat (3) begin
         @(negedge clk);
         check("t6_late_pulse_ignored", 32'(rsp_valid), 0);
      end
      check("t6_ops_done", 32'(ops_done), 0);
      cfg_lat = 0;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) req_data[CMD_W*i +: CMD_W] = mk(ALU_ADD, 2, i);
      req_valid = '1;
      base = grant_log.size();
      n = 0;
      while (grant_log.size() == base && n < 50) begin
         @(posedge clk);
         n++;
      end
      #1 req_valid = '0;
      if (grant_log.size() > base) check("t6_first_grant", 32'(grant_log[base]), 0);
      wait_idle(50);
      check("t6_first_rsp_id", 32'(got_id), 0);

      // Randomized soak against the model.
      cfg_lat = -1; cfg_rdy_max = 2;
      repeat (800) begin
         @(posedge clk);
         #1;
         req_valid = NUM_REQ'($urandom);
         for (int i = 0; i < NUM_REQ; i++) begin
            c.op = alu_op_e'($urandom_range(3, 0));
            c.a  = 4'($urandom);
            c.b  = ($urandom_range(3, 0) == 0) ? 4'd0 : 4'($urandom);
            req_data[CMD_W*i +: CMD_W] = c;
         end
         rsp_ready = ($urandom_range(3, 0) != 0);
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      wait_idle(200);
      @(negedge clk);
      check("final_ops_done", 32'(ops_done), 32'(m_count));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
